// File: rtl/mem_target_pkg.sv
// Shared types and PCI command constants for the burst memory target.
package mem_target_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    TERM,
    ABORT
  } state_t;

  localparam int CMD_MEM_RD  = 6;
  localparam int CMD_MEM_WR  = 7;
  localparam int CMD_MEM_RDM = 12;
  localparam int CMD_MEM_RDL = 14;
  localparam int CMD_MEM_WRI = 15;

  function automatic logic is_mem_cmd(
    input logic [15:0] cmd
  );
    return cmd[CMD_MEM_RD]  | cmd[CMD_MEM_WR]
         | cmd[CMD_MEM_RDM] | cmd[CMD_MEM_RDL]
         | cmd[CMD_MEM_WRI];
  endfunction

endpackage

// File: rtl/mem_target_burst_if.sv
// Target-side handshake bundle of the PCI core user interface.
interface mem_target_burst_if;

  logic        s_wrdn;
  logic [15:0] pci_cmd;
  logic [31:0] addr;
  logic [7:0]  base_hit;
  logic        addr_vld;
  logic        s_data;
  logic        s_data_vld;
  logic [31:0] adio_out;
  logic        s_ready;
  logic        s_term;
  logic        s_abort;

  modport master (
    output s_wrdn, pci_cmd, addr, base_hit,
    output addr_vld, s_data, s_data_vld, adio_out,
    input  s_ready, s_term, s_abort
  );

  modport slave (
    input  s_wrdn, pci_cmd, addr, base_hit,
    input  addr_vld, s_data, s_data_vld, adio_out,
    output s_ready, s_term, s_abort
  );

endinterface

// File: rtl/mem_target_ram.sv
// Single-port DEPTHx32 RAM, registered read, write-first.
module mem_target_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) begin
        mem[a] <= wd;
        rd     <= wd;
      end else begin
        rd <= mem[a];
      end
    end
  end

endmodule

// File: rtl/mem_target_burst.sv
// Burst PCI memory target on one BAR; MEM_TARGET_BURST_ABORT_EN
// enables window-range abort and top-of-memory disconnect.
module mem_target_burst
  import mem_target_pkg::*;
#(
  parameter int BAR_IDX     = 2,
  parameter int DEPTH       = 256,
  parameter int BAR_BITS    = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int BURST_MAX   = 16
) (
  input  logic               CLK,
  input  logic               reset,
  mem_target_burst_if.slave  bus,
  output wire  [31:0]        adio_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BURST_MAX) + 1;

  state_t        st, st_n;
  logic [AW-1:0] ptr;
  logic [BW-1:0] beats;
  logic [3:0]    wcnt;
  logic          dir;
  logic          claim, mem_cmd, oow;
  logic          last, beat, done;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   rd_q;

  wire unused_ok = ^{bus.addr, bus.pci_cmd, bus.base_hit};

  assign claim   = st == IDLE && bus.addr_vld
                 && bus.base_hit[BAR_IDX];
  assign mem_cmd = is_mem_cmd(bus.pci_cmd);
  assign beat    = st == XFER && bus.s_data_vld;
  assign done    = !bus.s_data && !bus.addr_vld;

`ifdef MEM_TARGET_BURST_ABORT_EN
  assign oow  = |(bus.addr[BAR_BITS-1:0] >> (AW + 2));
  assign last = beats == BW'(BURST_MAX - 1) || &ptr;
`else
  assign oow  = 1'b0;
  assign last = beats == BW'(BURST_MAX - 1);
`endif

  always_comb begin
    st_n        = st;
    bus.s_ready = 1'b0;
    bus.s_term  = 1'b0;
    bus.s_abort = 1'b0;
    unique case (st)
      IDLE: begin
        if (claim)
          st_n = !mem_cmd ? TERM : oow ? ABORT : WAIT;
      end
      WAIT: begin
        if (wcnt == 4'(WAIT_CYCLES)) st_n = XFER;
      end
      XFER: begin
        bus.s_ready = 1'b1;
        bus.s_term  = last;
        if (beat && last) st_n = TERM;
        else if (done)    st_n = IDLE;
      end
      TERM: begin
        bus.s_term = 1'b1;
        if (done) st_n = IDLE;
      end
      ABORT: begin
        bus.s_term = 1'b1;
`ifdef MEM_TARGET_BURST_ABORT_EN
        bus.s_abort = 1'b1;
`endif
        if (done) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      st    <= IDLE;
      ptr   <= '0;
      beats <= '0;
      wcnt  <= '0;
      dir   <= 1'b0;
    end else begin
      st <= st_n;
      if (claim) begin
        ptr   <= bus.addr[AW+1:2];
        dir   <= bus.s_wrdn;
        beats <= '0;
        wcnt  <= '0;
      end
      if (st == WAIT) wcnt <= wcnt + 4'd1;
      if (beat) begin
        ptr   <= ptr + AW'(1);
        beats <= beats + BW'(1);
      end
    end
  end

  // Reads fetch one word ahead so adio_in is valid in every XFER cycle.
  assign ram_en = (st == WAIT && wcnt == '0 && !dir)
                | (beat && !reset);
  assign ram_we = beat && dir && !reset;
  assign ram_a  = (beat && !dir) ? ptr + AW'(1) : ptr;

  mem_target_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK (CLK),
    .en  (ram_en),
    .we  (ram_we),
    .a   (ram_a),
    .wd  (bus.adio_out),
    .rd  (rd_q)
  );

  assign adio_in = (!dir && bus.s_data
                   && (st == XFER || st == TERM))
                 ? rd_q : 32'hz;

endmodule
